fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage, directly upstream of the instruction memory.
//   - Owns the program counter and drives imem_pc; the memory returns imem_inst combinationally in the same cycle.
//   - Buffers {pc, inst} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
//   - Handles branch/jump redirects.
//   - Raises a sticky fault on a misaligned redirect target.
// PARAMETERS
//   PC_W     32           PC / address width
//   INST_W   32           instruction width
//   DEPTH    2            queue entries; power of 2, >=2
//   RESET_PC 32'h0000_0000 first fetch address; [1:0] must be 0 (sim assertion)
// PORTS
//   clk            in  1       clock, all state on rising edge
//   rst            in  1       synchronous reset, active-high
//   imem_pc        out PC_W    fetch address to instruction memory (= pc_reg, combinational)
//   imem_inst      in  INST_W  instruction word returned for imem_pc, same cycle
//   redirect_valid in  1       branch/jump taken; load redirect_pc
//   redirect_pc    in  PC_W    new fetch target
//   out_valid      out 1       queue head valid to decode
//   out_ready      in  1       decode accepts head this cycle
//   out_inst       out INST_W  head instruction
//   out_pc         out PC_W    PC of head instruction
//   fault          out 1       sticky: misaligned redirect seen
//   fault_pc       out PC_W    offending redirect_pc
// BEHAVIOUR
//   Reset values:
//     - pc_reg=RESET_PC; queue empty (count=0, rd/wr ptr=0); out_valid=0.
//     - out_inst/out_pc=0; fault=0; fault_pc=0; state=RUN.
//   States:
//     - RUN: normal fetch.
//     - FAULT: no fetch, no queue writes; leave only via rst.
//   Pop:
//     - occurs when out_valid && out_ready.
//     - out_inst/out_pc come from FIFO storage and are held stable while out_valid && !out_ready.
//   Push (RUN, !redirect_valid):
//     - occurs when count<DEPTH, or count==DEPTH with a pop in the same cycle.
//     - Write {pc_reg, imem_inst}; pc_reg <= pc_reg+4, wrapping mod 2^PC_W (0xFFFF_FFFC -> 0).
//     - No push -> pc_reg holds.
//   Simultaneous push+pop: count unchanged; full queue stays full and keeps streaming.
//   Redirect (highest priority, RUN):
//     - The same-cycle pop completes (decode consumed it); the queue is then flushed (count=0, ptrs=0).
//     - The same-cycle fetch is discarded.
//     - Next pc_reg: pc_reg <= redirect_pc.
//     - out_valid is 0 the next cycle; the first redirected instruction is valid 2 cycles after redirect_valid is sampled.
//   Misaligned redirect (redirect_pc[1:0]!=0):
//     - Next state: FAULT.
//     - Register updates: fault<=1, fault_pc<=redirect_pc, queue flushed, pc_reg unchanged.
//     - redirect_valid is ignored in FAULT; out_valid stays 0.
//   Latency:
//     - After rst deasserts, the RESET_PC word is pushed at the first edge; out_valid rises the following cycle.
//     - Steady state with out_ready=1: one instruction per cycle.
//   rst mid-operation: everything returns to reset values next cycle; queued entries are lost; fault clears.
//   Count width: $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined:
//     - Adds outputs perf_fetch_cnt[31:0] (+1 per push) and perf_flush_cnt[31:0] (+1 per accepted redirect, incl. misaligned).
//     - Both reset to 0 and wrap at 2^32.
//   Undefined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING
//   1 Reset, out_ready=1, memory word k = k -> out_pc 0,4,8,... with out_inst 0,1,2,...; out_valid from 2nd cycle after rst low, no bubbles.
//   2 out_ready=0 for 5 cycles after fill -> exactly DEPTH entries held, imem_pc frozen at RESET_PC+4*DEPTH; release -> in-order stream, no loss, no duplicates.
//   3 redirect_valid with redirect_pc=0x100 while full -> out_valid=0 next cycle, then out_pc=0x100, 0x104; no stale entries appear.
//   4 redirect_pc=0x102 -> fault=1, fault_pc=0x102, out_valid stays 0, later redirect to 0x200 ignored; rst clears fault, fetch restarts at RESET_PC.
//   5 RESET_PC=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
//   6 FETCH_PERF_CNT_EN: 10 pushes, 2 redirects -> perf_fetch_cnt=10, perf_flush_cnt=2; rst -> both 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, buffers {pc, inst} pairs for decode, handles redirects
// and traps misaligned targets. Optional perf counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_pc,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic              fault,
  output logic [PC_W-1:0]   fault_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {ST_RUN, ST_FAULT} state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic              r_fault;
  logic [PC_W-1:0]   r_fault_pc;
  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];

  logic w_run;
  logic w_redirect;
  logic w_misaligned;
  logic w_pop;
  logic w_push;

  a_reset_pc_aligned: assert property (@(posedge clk) RESET_PC[1:0] == 2'b00);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (redirect_valid && w_misaligned) w_state_nxt = ST_FAULT;
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // FSM: outputs and handshake qualifiers
  always_comb begin
    w_run     = (r_state == ST_RUN);
    out_valid = w_run && (r_count != '0);
    out_pc    = out_valid ? r_pc_mem[r_rd_ptr]   : '0;
    out_inst  = out_valid ? r_inst_mem[r_rd_ptr] : '0;
  end

  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign w_redirect   = w_run && redirect_valid;
  assign w_pop        = out_valid && out_ready;
  // A full queue may still accept a fetch when the head leaves in the same cycle.
  assign w_push       = w_run && !redirect_valid && ((r_count < DEPTH_C) || w_pop);

  assign imem_pc  = r_pc;
  assign fault    = r_fault;
  assign fault_pc = r_fault_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (w_redirect) begin
      // The same-cycle pop is consumed by decode, then everything queued is dropped.
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      if (w_misaligned) begin
        r_fault    <= 1'b1;
        r_fault_pc <= redirect_pc;
      end else begin
        r_pc <= redirect_pc;
      end
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_pc     <= r_pc + PC_W'(4);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: queue storage is not reset; out_valid gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_pc;
      r_inst_mem[r_wr_ptr] <= imem_inst;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (w_push)     perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (w_redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
